dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester round-robin arbiter and sequencer in front of the synchronous-write, asynchronous-read `DataMemory`. It accepts single-word read/write commands from requester 0 (CPU load/store port) and requester 1 (loader/DMA port) through valid/ready handshakes. It drives the memory's `en`/`we`/`addr`/`di` from registers and returns read data, or a write acknowledge, as a one-cycle response pulse. It sits between the datapath's memory stage and the memory instance; the memory's `_do` feeds back into this block.

## Interface
- `addWidth`, 6: address width; must match the memory instance.
- `dataWidth`, 16: data word width; must match the memory instance.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  bit i: requester i presents a command.
- `req_ready`  out  2  bit i: arbiter accepts requester i this cycle.
- `req_we`  in  2  bit i: 1 = write, 0 = read.
- `req_addr`  in  2*addWidth  requester i's address in bits [i*addWidth +: addWidth].
- `req_wdata`  in  2*dataWidth  requester i's write data in bits [i*dataWidth +: dataWidth].
- `rsp_valid`  out  2  one-hot; bit i pulses for one cycle when requester i's access completes.
- `rsp_data`  out  dataWidth  read data for the completed access.
- `mem_en`, `mem_we`  out  1 each  memory enable and write enable; both registered.
- `mem_addr`  out  addWidth  memory address; registered.
- `mem_di`  out  dataWidth  memory write data; registered.
- `mem_do`  in  dataWidth  memory asynchronous read data.

## Operation
- FSM states:
  - IDLE: accepts commands.
  - ACCESS: the memory is driven for one cycle.
  - Any other encoding → IDLE.
- Arbitration in IDLE:
  - winner = sole valid requester.
  - If both are valid, winner = requester other than `last_grant`.
  - `req_ready` is combinational: one-hot winner in IDLE, 0 in ACCESS or when no request is valid.
- Handshake: requester i's command is accepted at the edge where `req_valid[i] & req_ready[i]`. At that edge:
  - `mem_addr`, `mem_we`, `mem_di` ← winner's fields; `mem_en` ← 1.
  - `owner` ← i; `last_grant` ← i.
  - state → ACCESS.
- ACCESS lasts exactly one cycle. At its closing edge:
  - `rsp_data` ← `mem_do`. The memory is read-first, so a write returns the pre-write word.
  - `rsp_valid[owner]` ← 1.
  - `mem_en`, `mem_we` ← 0.
  - state → IDLE.
- `rsp_valid` clears after one cycle. `rsp_data` holds its value until the next completion.
- `mem_addr` and `mem_di` hold their last values when idle.
- Reset values:
  - state IDLE, `last_grant` = 1 (requester 0 wins the first tie).
  - `mem_en`, `mem_we`, `rsp_valid` = 0.
  - `mem_addr`, `mem_di`, `rsp_data`, `owner` = 0.
- Reset mid-operation:
  - `rst` asserted during ACCESS: the in-flight write still commits in memory, because the memory samples `mem_en`/`mem_we` at the same edge.
  - No response is produced for that access; all outputs take reset values.
- Requester rules:
  - A requester must hold `req_valid` and its fields stable until accepted.
  - Dropping `req_valid` before acceptance is legal and withdraws the command. No arbitration state changes.

## Timing
- Accept at edge E0; ACCESS occupies E0–E1; a write commits at E1; the response is visible E1–E2.
- Latency: 2 cycles from the acceptance cycle to `rsp_valid`.
- Throughput: one access per 2 cycles.
  - IDLE after E1 accepts a new command, so `req_ready` can be high in the same cycle as `rsp_valid`.
  - With both requesters continuously valid, grants alternate 0,1,0,1…, each requester receiving one access every 4 cycles.
- No combinational path from `mem_do` to any output. `req_ready` depends combinationally only on state, `req_valid`, and `last_grant`.

## Structure
- Package `dmem_pkg`:
  - `NREQ` = 2
  - requester ID constants `REQ_CPU` = 0, `REQ_LOAD` = 1
  - FSM state type with `S_IDLE` and `S_ACCESS`
- Sub-module `rr_pick2`: combinational round-robin picker; inputs `req_valid` and `last_grant`, outputs one-hot grant and its index.
- Top level holds the FSM, the command registers and the response registers.

## Test plan
- Reset, then idle → `mem_en`=0, `req_ready`=00, `rsp_valid`=00 for 10 cycles.
- Requester 0 writes 0xBEEF to address 5, then requester 1 reads address 5.
  - Write response: `rsp_valid`=01 two cycles after acceptance, `rsp_data` = prior contents.
  - Read response: `rsp_valid`=10, `rsp_data`=0xBEEF.
- Both requesters valid from the first cycle after reset, 8 accesses → grant order 0,1,0,1,0,1,0,1; each `rsp_valid` pulse is exactly one cycle; `req_ready` is never 11.
- Only requester 1 valid for 4 accesses → all granted to 1, back-to-back every 2 cycles; requester 0 then wins the first subsequent tie.
- Write 0x1234 to address 63, then read address 63 → 0x1234. This checks the top address with no wrap to address 0.
- Assert `rst` during the ACCESS cycle of a write of 0xA5A5 to address 9.
  - No `rsp_valid` pulse; outputs return to reset values.
  - A later read of address 9 returns 0xA5A5.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam int unsigned NREQ = 2;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not granted last time wins.
module rr_pick2
  import dmem_pkg::*;
(
  input  logic [NREQ-1:0] req_valid,
  input  logic            last_grant,
  output logic [NREQ-1:0] grant,
  output logic            grant_idx
);

  always_comb begin
    grant_idx = REQ_CPU;
    grant     = '0;
    unique case (req_valid)
      2'b01:   grant_idx = REQ_CPU;
      2'b10:   grant_idx = REQ_LOAD;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = REQ_CPU;
    endcase
    if (|req_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for two requesters in front of DataMemory;
// one registered memory access per accepted command, one-cycle response pulse.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int addWidth  = 6,
  parameter int dataWidth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [2*addWidth-1:0]    req_addr,
  input  logic [2*dataWidth-1:0]   req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [dataWidth-1:0]     rsp_data,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [addWidth-1:0]      mem_addr,
  output logic [dataWidth-1:0]     mem_di,
  input  logic [dataWidth-1:0]     mem_do
);

  state_t state, state_next;
  logic   last_grant;
  logic   owner;

  logic [NREQ-1:0]      grant;
  logic                 grant_idx;
  logic                 accept;
  logic [addWidth-1:0]  sel_addr;
  logic [dataWidth-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    req_ready = (state == S_IDLE) ? grant : '0;
    accept    = |(req_valid & req_ready);
    sel_addr  = grant_idx ? req_addr[2*addWidth-1:addWidth]    : req_addr[addWidth-1:0];
    sel_wdata = grant_idx ? req_wdata[2*dataWidth-1:dataWidth] : req_wdata[dataWidth-1:0];
  end

  always_comb begin
    state_next = S_IDLE;
    unique case (state)
      S_IDLE:   state_next = accept ? S_ACCESS : S_IDLE;
      S_ACCESS: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= REQ_LOAD;
      owner      <= REQ_CPU;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_di     <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= '0;
      if (state == S_IDLE && accept) begin
        mem_en     <= 1'b1;
        mem_we     <= req_we[grant_idx];
        mem_addr   <= sel_addr;
        mem_di     <= sel_wdata;
        owner      <= grant_idx;
        last_grant <= grant_idx;
      end
      // Read-first memory: mem_do still shows the pre-write word at this edge.
      if (state == S_ACCESS) begin
        rsp_data         <= mem_do;
        rsp_valid[owner] <= 1'b1;
        mem_en           <= 1'b0;
        mem_we           <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with an attached read-first memory.
module tb_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_di;
  logic [DW-1:0]   mem_do;

  always #5 clk = ~clk;

  dmem_arbiter #(.addWidth(AW), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_do(mem_do)
  );

  // DataMemory stand-in: synchronous write, asynchronous read.
  logic [DW-1:0] mem [64];
  assign mem_do = mem[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_di;

  // Reference model state
  logic [DW-1:0] ref_mem [64];
  bit            m_busy;
  bit            m_last;
  bit            m_pwe;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pdata;

  typedef struct {
    logic [1:0]    v;
    logic [DW-1:0] d;
    int            c;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && rsp_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.v});
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.d});
        chk("rsp_cycle", cyc, e.c);
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("rst_mem_di", {16'd0, mem_di}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_busy = 0; m_last = 1;
    @(negedge clk);
    chk_reset_outputs();
  endtask

  // One cycle: apply inputs, then check ready/memory side against the model.
  task automatic drive_cycle(input logic [1:0] v, input logic [1:0] w,
                             input logic [2*AW-1:0] a, input logic [2*DW-1:0] d,
                             output int acc);
    logic [1:0] exp_ready;
    int idx;
    @(posedge clk); #1;
    req_valid = v; req_we = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    if (m_busy) begin
      chk("access_mem_en", {31'd0, mem_en}, 32'd1);
      chk("access_mem_we", {31'd0, mem_we}, {31'd0, m_pwe});
      chk("access_mem_addr", {26'd0, mem_addr}, {26'd0, m_paddr});
      if (m_pwe) chk("access_mem_di", {16'd0, mem_di}, {16'd0, m_pdata});
    end else begin
      chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
    end
    idx = -1;
    if (!m_busy) begin
      if (v == 2'b11)      idx = m_last ? 0 : 1;
      else if (v == 2'b01) idx = 0;
      else if (v == 2'b10) idx = 1;
    end
    exp_ready = (idx < 0) ? 2'b00 : 2'(1 << idx);
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
    acc = idx;
    if (idx >= 0) begin
      exp_t e;
      m_paddr = a[idx*AW +: AW];
      m_pdata = d[idx*DW +: DW];
      m_pwe   = w[idx];
      e.v = exp_ready;
      e.d = ref_mem[m_paddr];
      e.c = cyc + 2;
      sb.push_back(e);
      if (m_pwe) ref_mem[m_paddr] = m_pdata;
      m_last = idx[0];
      m_busy = 1;
    end else begin
      m_busy = 0;
    end
  endtask

  task automatic issue(input int i, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    int acc;
    logic [2*AW-1:0] a;
    logic [2*DW-1:0] d;
    logic [1:0] v, w;
    a = $urandom; d = $urandom;
    a[i*AW +: AW] = addr;
    d[i*DW +: DW] = data;
    v = 2'(1 << i);
    w = we ? v : 2'b00;
    for (int k = 0; k < 8; k++) begin
      drive_cycle(v, w, a, d, acc);
      if (acc >= 0) return;
    end
    chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    int acc;
    for (int k = 0; k < n; k++) drive_cycle(2'b00, 2'b00, '0, '0, acc);
  endtask

  initial begin
    int acc;
    int order[$];
    bit pv[2];
    bit pw[2];
    logic [AW-1:0] pa[2];
    logic [DW-1:0] pd[2];

    for (int i = 0; i < 64; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    m_busy = 0; m_last = 1;

    do_reset();
    mon_en = 1;
    idle(10);

    // Tie from the start: grants must alternate starting with requester 0.
    while (order.size() < 8 && cyc < 200) begin
      drive_cycle(2'b11, 2'($urandom), 12'($urandom), 32'($urandom), acc);
      if (acc >= 0) order.push_back(acc);
    end
    chk("tie_accept_count", order.size(), 8);
    for (int k = 0; k < order.size(); k++) chk("tie_order", order[k], k % 2);
    idle(3);

    issue(0, 1, 6'd5, 16'hBEEF);
    issue(1, 0, 6'd5, 16'h0000);
    idle(3);

    // Requester 1 alone: back-to-back every 2 cycles, then a tie goes to 0.
    order.delete();
    for (int k = 0; k < 8; k++) begin
      drive_cycle(2'b10, 2'($urandom), 12'($urandom), 32'($urandom), acc);
      if (acc >= 0) order.push_back(k);
    end
    chk("solo1_accepts", order.size(), 4);
    drive_cycle(2'b11, 2'b00, 12'($urandom), 32'($urandom), acc);
    chk("tie_after_solo1", acc, 0);
    idle(3);

    issue(0, 1, 6'd63, 16'h1234);
    issue(1, 0, 6'd63, 16'h0000);
    issue(0, 0, 6'd0, 16'h0000);
    idle(3);

    // Reset while a write is in ACCESS: no response, memory still commits.
    issue(0, 1, 6'd9, 16'hA5A5);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("rst_access_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_busy = 0; m_last = 1;
    @(negedge clk);
    chk_reset_outputs();
    idle(3);
    issue(1, 0, 6'd9, 16'h0000);
    idle(3);

    // Randomized traffic with withdrawals.
    pv[0] = 0; pv[1] = 0;
    for (int k = 0; k < 400; k++) begin
      logic [1:0] v, w;
      logic [2*AW-1:0] a;
      logic [2*DW-1:0] d;
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && ($urandom % 3 == 0)) begin
          pv[i] = 1;
          pw[i] = $urandom % 2;
          pa[i] = ($urandom % 2) ? AW'($urandom % 4) : AW'($urandom);
          if ($urandom % 8 == 0) pa[i] = 6'd63;
          pd[i] = DW'($urandom);
        end else if (pv[i] && ($urandom % 16 == 0)) begin
          pv[i] = 0;
        end
      end
      v = {pv[1], pv[0]};
      w = {pw[1], pw[0]};
      a = {pa[1], pa[0]};
      d = {pd[1], pd[0]};
      drive_cycle(v, w, a, d, acc);
      if (acc >= 0) pv[acc] = 0;
    end

    idle(4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
